// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter with one-hot grant, bounded hold
// and block enable; grant and index are registered.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       gnt_n;
  logic [1:0]       idx_n;
  logic             busy_n;
  logic             to_n;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic             win_vld;
  logic [3:0]       win_oh;

  // First requester found scanning from ptr upward, mod 4
  always_comb begin
    win     = '0;
    cand    = '0;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Winner index to one-hot grant
  always_comb begin
    win_oh = 4'b0000;
    unique case (win)
      2'd0: win_oh = 4'b0001;
      2'd1: win_oh = 4'b0010;
      2'd2: win_oh = 4'b0100;
      2'd3: win_oh = 4'b1000;
      default: win_oh = 4'b0000;
    endcase
  end

  // Next-state and registered-output values
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    busy_n  = busy;
    to_n    = 1'b0;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        gnt_n  = 4'b0000;
        busy_n = 1'b0;
        if (EN && win_vld) begin
          state_n = GRANT;
          gnt_n   = win_oh;
          idx_n   = win;
          busy_n  = 1'b1;
          cnt_n   = ONE;
        end
      end
      GRANT: begin
        if (!EN || !req[gnt_idx]) begin
          state_n = RELEASE;
          gnt_n   = 4'b0000;
          busy_n  = 1'b0;
        end else if (cnt == MAXC) begin
          state_n = RELEASE;
          gnt_n   = 4'b0000;
          busy_n  = 1'b0;
          to_n    = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      RELEASE: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        busy_n  = 1'b0;
        ptr_n   = gnt_idx + 2'd1;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      gnt_idx <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 2'd0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      busy    <= busy_n;
      timeout <= to_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: queued expected outputs
// checked by a monitor against two parameterisations.
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       EN;
  logic [3:0] req;

  logic [3:0] g16, g4;
  logic [1:0] i16, i4;
  logic       b16, b4, t16, t4;

  int tests = 0;
  int fails = 0;
  bit async_arm = 1'b0;

  typedef struct packed {
    logic       s;
    logic [3:0] g;
    logic [1:0] i;
    logic       b;
    logic       t;
  } exp_t;

  exp_t  q[$];
  string nq[$];

  rr_decode_arbiter #(.MAX_HOLD(16), .CNT_W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .EN(EN), .req(req),
    .gnt(g16), .gnt_idx(i16), .busy(b16), .timeout(t16)
  );

  rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .EN(EN), .req(req),
    .gnt(g4), .gnt_idx(i4), .busy(b4), .timeout(t4)
  );

  always #5 clk = ~clk;

  task automatic check_one();
    exp_t  x;
    string n;
    logic [7:0] act, want;
    x = q.pop_front();
    n = nq.pop_front();
    act  = x.s ? {g4, i4, b4, t4} : {g16, i16, b16, t16};
    want = {x.g, x.i, x.b, x.t};
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got gnt=%b idx=%0d busy=%b to=%b, want gnt=%b idx=%0d busy=%b to=%b",
               n, act[7:4], act[3:2], act[1], act[0],
               want[7:4], want[3:2], want[1], want[0]);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (q.size() > 0) check_one();
  end

  always @(negedge rst_n) begin
    if (async_arm) begin
      #1;
      if (q.size() > 0) check_one();
    end
  end

  always @(negedge clk) begin
    if (!$onehot0(g16) || !$onehot0(g4)) begin
      fails++;
      $display("FAIL onehot: got g16=%b g4=%b, want at most one bit", g16, g4);
    end
  end

  task automatic cyc(input logic [3:0] r, input logic e,
                     input logic s, input logic [3:0] g,
                     input logic [1:0] i, input logic b,
                     input logic t, input string n);
    req = r;
    EN  = e;
    q.push_back('{s, g, i, b, t});
    nq.push_back(n);
    @(posedge clk);
    #3;
  endtask

  task automatic areset(input string n);
    #3;
    async_arm = 1'b1;
    q.push_back('{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});
    nq.push_back(n);
    rst_n = 1'b0;
    #3;
    async_arm = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    EN    = 1'b1;

    for (int k = 0; k < 3; k++)
      cyc(4'b0000, 1, 0, 4'b0000, 2'd0, 0, 0, "reset");
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++)
      cyc(4'b0000, 1, 0, 4'b0000, 2'd0, 0, 0, "idle");

    for (int k = 0; k < 5; k++)
      cyc(4'b0100, 1, 0, 4'b0100, 2'd2, 1, 0, "single_hold");
    cyc(4'b0000, 1, 0, 4'b0000, 2'd2, 0, 0, "single_release");
    cyc(4'b0000, 1, 0, 4'b0000, 2'd2, 0, 0, "single_idle");
    cyc(4'b1001, 1, 0, 4'b1000, 2'd3, 1, 0, "ptr_is_3");
    cyc(4'b0000, 1, 0, 4'b0000, 2'd3, 0, 0, "ptr3_release");
    cyc(4'b0000, 1, 0, 4'b0000, 2'd3, 0, 0, "ptr3_idle");

    for (int k = 0; k < 5; k++) begin
      logic [1:0] w;
      logic [3:0] oh;
      w  = 2'(k);
      oh = 4'b0001 << w;
      cyc(4'b1111, 1, 0, oh, w, 1, 0, "rr_grant_a");
      cyc(4'b1111, 1, 0, oh, w, 1, 0, "rr_grant_b");
      cyc(4'b1111 & ~oh, 1, 0, 4'b0000, w, 0, 0, "rr_release");
      cyc(4'b1111, 1, 0, 4'b0000, w, 0, 0, "rr_idle");
    end
    cyc(4'b0000, 1, 0, 4'b0000, 2'd0, 0, 0, "rr_drain");

    cyc(4'b1000, 1, 0, 4'b1000, 2'd3, 1, 0, "en_grant");
    cyc(4'b1000, 1, 0, 4'b1000, 2'd3, 1, 0, "en_grant2");
    cyc(4'b1000, 0, 0, 4'b0000, 2'd3, 0, 0, "en_drop");
    for (int k = 0; k < 4; k++)
      cyc(4'b1111, 0, 0, 4'b0000, 2'd3, 0, 0, "en_low_block");
    cyc(4'b0000, 1, 0, 4'b0000, 2'd3, 0, 0, "en_restore");

    rst_n = 1'b0;
    cyc(4'b0000, 1, 1, 4'b0000, 2'd0, 0, 0, "to_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      cyc(4'b0010, 1, 1, 4'b0010, 2'd1, 1, 0, "to_hold");
    cyc(4'b0010, 1, 1, 4'b0000, 2'd1, 0, 1, "to_pulse");
    cyc(4'b0011, 1, 1, 4'b0000, 2'd1, 0, 0, "to_pulse_end");
    cyc(4'b0011, 1, 1, 4'b0001, 2'd0, 1, 0, "to_next_0001");
    for (int k = 0; k < 3; k++)
      cyc(4'b0011, 1, 1, 4'b0001, 2'd0, 1, 0, "to_hold0");
    cyc(4'b0011, 0, 1, 4'b0000, 2'd0, 0, 0, "en_over_to");
    cyc(4'b0011, 1, 1, 4'b0000, 2'd0, 0, 0, "en_over_idle");
    cyc(4'b0011, 1, 1, 4'b0010, 2'd1, 1, 0, "to_after_en");
    cyc(4'b0000, 1, 1, 4'b0000, 2'd1, 0, 0, "to_drain");

    rst_n = 1'b0;
    cyc(4'b0000, 1, 0, 4'b0000, 2'd0, 0, 0, "ar_prereset");
    rst_n = 1'b1;
    cyc(4'b0100, 1, 0, 4'b0100, 2'd2, 1, 0, "ar_grant");
    cyc(4'b0100, 1, 0, 4'b0100, 2'd2, 1, 0, "ar_grant2");
    areset("ar_immediate");
    cyc(4'b0100, 1, 0, 4'b0000, 2'd0, 0, 0, "ar_held");
    rst_n = 1'b1;
    cyc(4'b0100, 1, 0, 4'b0100, 2'd2, 1, 0, "ar_regrant");
    cyc(4'b0000, 1, 0, 4'b0000, 2'd2, 0, 0, "ar_release");

    repeat (2) @(posedge clk);
    #4;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
